// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX stream arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_HDR_BASE = 32'hA0;

    // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin finder: first eligible index after last_owner, with wrap.
import uart_arb_pkg::*;

module uart_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             found_o
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;

    // Rotate so bit 0 is the requester right after the last owner.
    always_comb begin
        doubled  = {eligible_i, eligible_i};
        rotated  = N_REQ'(doubled >> (32'(last_owner_i) + 32'd1));
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found_o  = 1'b1;
                winner_o = IDX_W'((32'(last_owner_i) + 32'd1 + 32'(k)) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-stream UART TX among N_REQ requesters.
import uart_arb_pkg::*;

module uart_tx_stream_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_BIT    = 8,
    parameter bit          HEADER_EN   = 1'b1,
    parameter int unsigned HDR_BASE    = DEFAULT_HDR_BASE,
    parameter int unsigned MAX_PKT_LEN = 64
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ*DATA_BIT-1:0] s_axis_tdata,
    input  logic [N_REQ-1:0]          s_axis_tvalid,
    input  logic [N_REQ-1:0]          s_axis_tlast,
    output logic [N_REQ-1:0]          s_axis_tready,
    output logic [DATA_BIT-1:0]       m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic [N_REQ-1:0]          req_mask,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic [N_REQ-1:0]          trunc_err,
    input  logic [N_REQ-1:0]          err_clr
);

    localparam int unsigned IDX_W = clog2(N_REQ);
    localparam int unsigned CNT_W = clog2(MAX_PKT_LEN) + 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    trunc_q, trunc_d;
    logic [N_REQ-1:0]    trunc_set;

    logic [DATA_BIT-1:0] req_data [N_REQ];
    logic [DATA_BIT-1:0] sel_data;
    logic [DATA_BIT-1:0] hdr_word;
    logic                sel_valid;
    logic                sel_last;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_data[g] = s_axis_tdata[g*DATA_BIT +: DATA_BIT];
    end

    assign sel_data  = req_data[idx_q];
    assign sel_valid = s_axis_tvalid[idx_q];
    assign sel_last  = s_axis_tlast[idx_q];
    assign hdr_word  = DATA_BIT'(HDR_BASE + 32'(idx_q));

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible_i   (s_axis_tvalid & req_mask),
        .last_owner_i (last_q),
        .winner_o     (pick_idx),
        .found_o      (pick_found)
    );

    // Output mux: header from owner index, payload passed straight through.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        case (state_q)
            ST_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word;
            end
            ST_DATA: begin
                m_axis_tvalid = sel_valid;
                m_axis_tdata  = sel_data;
                s_axis_tready = N_REQ'(m_axis_tready) << idx_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        trunc_set = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    grant_d = N_REQ'(1) << pick_idx;
                    state_d = HEADER_EN ? ST_HEADER : ST_DATA;
                end
            end
            ST_HEADER: begin
                if (m_axis_tready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sel_valid && m_axis_tready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Packet ends on tlast or when the length budget is spent.
                    if (sel_last || (cnt_q == CNT_W'(MAX_PKT_LEN - 1))) begin
                        state_d = ST_IDLE;
                        last_d  = idx_q;
                        grant_d = '0;
                        cnt_d   = '0;
                        if (!sel_last) trunc_set = N_REQ'(1) << idx_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        trunc_d = (trunc_q & ~err_clr) | trunc_set;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Directed bench for uart_tx_stream_arbiter: 4 requesters, header on, 4-word length limit.
module tb_uart_tx_stream_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [3:0]  req_mask;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  trunc_err;
    logic [3:0]  err_clr;

    int total = 0;
    int bad   = 0;

    logic [7:0] srcd [4][$];
    bit         srcl [4][$];
    logic [7:0] outq [$];
    logic [7:0] exp_q [$];
    logic [3:0] glog [$];
    logic       blog [$];

    uart_tx_stream_arbiter #(
        .N_REQ       (4),
        .DATA_BIT    (8),
        .HEADER_EN   (1'b1),
        .HDR_BASE    (32'hA0),
        .MAX_PKT_LEN (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .req_mask      (req_mask),
        .grant         (grant),
        .busy          (busy),
        .trunc_err     (trunc_err),
        .err_clr       (err_clr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (srcd[i].size() > 0) begin
                s_axis_tdata[i*8 +: 8] = srcd[i][0];
                s_axis_tvalid[i]       = 1'b1;
                s_axis_tlast[i]        = srcl[i][0];
            end else begin
                s_axis_tdata[i*8 +: 8] = 8'h00;
                s_axis_tvalid[i]       = 1'b0;
                s_axis_tlast[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int ch, input logic [7:0] d, input bit l);
        srcd[ch].push_back(d);
        srcl[ch].push_back(l);
    endtask

    // One clock: observe handshakes at negedge, retire accepted source words after posedge.
    task automatic step();
        logic [3:0] popv;
        @(negedge aclk);
        popv = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) outq.push_back(m_axis_tdata);
        glog.push_back(grant);
        blog.push_back(busy);
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (popv[i]) begin
                void'(srcd[i].pop_front());
                void'(srcl[i].pop_front());
            end
        end
        drive();
        #1;
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        m_axis_tready = 1'b0;
        req_mask      = 4'hF;
        err_clr       = 4'h0;
        for (int i = 0; i < 4; i++) begin
            srcd[i].delete();
            srcl[i].delete();
        end
        drive();
        repeat (2) @(posedge aclk);
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
        total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("FAIL reset_sready got=%b want=0000", s_axis_tready); end
        total++; if (trunc_err !== 4'b0000) begin bad++; $display("FAIL reset_trunc got=%b want=0000", trunc_err); end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        outq.delete();
        glog.delete();
        blog.delete();
    endtask

    task automatic test_single_packet();
        logic [3:0] gexp [6];
        logic       bexp [6];
        test_reset();
        m_axis_tready = 1'b1;
        load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
        drive(); #1;
        repeat (6) step();
        gexp = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        bexp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            total++; if (glog[i] !== gexp[i]) begin bad++; $display("FAIL single_grant[%0d] got=%b want=%b", i, glog[i], gexp[i]); end
            total++; if (blog[i] !== bexp[i]) begin bad++; $display("FAIL single_busy[%0d] got=%b want=%b", i, blog[i], bexp[i]); end
        end
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        total++; if (outq.size() != exp_q.size()) begin bad++; $display("FAIL single_len got=%0d want=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= outq.size() || outq[i] !== exp_q[i]) begin bad++; $display("FAIL single_word[%0d] got=%h want=%h", i, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        m_axis_tready = 1'b1;
        load(0, 8'h51, 1'b0); load(0, 8'h52, 1'b1);
        load(2, 8'h71, 1'b0); load(2, 8'h72, 1'b1);
        drive(); #1;
        repeat (12) step();
        load(0, 8'h53, 1'b0); load(0, 8'h54, 1'b1); load(0, 8'h55, 1'b0); load(0, 8'h56, 1'b1);
        load(2, 8'h73, 1'b0); load(2, 8'h74, 1'b1); load(2, 8'h75, 1'b0); load(2, 8'h76, 1'b1);
        drive(); #1;
        repeat (20) step();
        exp_q = '{8'hA0, 8'h51, 8'h52, 8'hA2, 8'h71, 8'h72,
                  8'hA0, 8'h53, 8'h54, 8'hA2, 8'h73, 8'h74,
                  8'hA0, 8'h55, 8'h56, 8'hA2, 8'h75, 8'h76};
        total++; if (outq.size() != exp_q.size()) begin bad++; $display("FAIL rr_len got=%0d want=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= outq.size() || outq[i] !== exp_q[i]) begin bad++; $display("FAIL rr_word[%0d] got=%h want=%h", i, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        test_reset();
        load(1, 8'h31, 1'b0); load(1, 8'h32, 1'b0); load(1, 8'h33, 1'b1);
        drive(); #1;
        step();
        for (int k = 0; k < 5; k++) begin
            total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL hdr_stall_valid[%0d] got=%b want=1", k, m_axis_tvalid); end
            total++; if (m_axis_tdata !== 8'hA1) begin bad++; $display("FAIL hdr_stall_data[%0d] got=%h want=a1", k, m_axis_tdata); end
            total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("FAIL hdr_stall_sready[%0d] got=%b want=0000", k, s_axis_tready); end
            step();
        end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL data_stall_valid[%0d] got=%b want=1", k, m_axis_tvalid); end
            total++; if (m_axis_tdata !== 8'h31) begin bad++; $display("FAIL data_stall_data[%0d] got=%h want=31", k, m_axis_tdata); end
            total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("FAIL data_stall_sready[%0d] got=%b want=0000", k, s_axis_tready); end
            step();
        end
        m_axis_tready = 1'b1;
        repeat (6) step();
        exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33};
        total++; if (outq.size() != exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d want=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= outq.size() || outq[i] !== exp_q[i]) begin bad++; $display("FAIL stall_word[%0d] got=%h want=%h", i, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_truncation();
        test_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) load(1, 8'(8'h40 + i), 1'b0);
        drive(); #1;
        err_clr = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            if (outq.size() >= 5) break;
            step();
        end
        err_clr = 4'b0000;
        total++; if (trunc_err !== 4'b0010) begin bad++; $display("FAIL trunc_set_wins got=%b want=0010", trunc_err); end
        repeat (14) step();
        exp_q = '{8'hA1, 8'h40, 8'h41, 8'h42, 8'h43, 8'hA1, 8'h44, 8'h45};
        total++; if (outq.size() != exp_q.size()) begin bad++; $display("FAIL trunc_len got=%0d want=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= outq.size() || outq[i] !== exp_q[i]) begin bad++; $display("FAIL trunc_word[%0d] got=%h want=%h", i, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]); end
        end
        total++; if (trunc_err !== 4'b0010) begin bad++; $display("FAIL trunc_sticky got=%b want=0010", trunc_err); end
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL trunc_locked_grant got=%b want=0010", grant); end
        err_clr = 4'b0010;
        step();
        err_clr = 4'b0000;
        total++; if (trunc_err !== 4'b0000) begin bad++; $display("FAIL trunc_clear got=%b want=0000", trunc_err); end
    endtask

    task automatic test_mask();
        test_reset();
        m_axis_tready = 1'b1;
        req_mask = 4'b1110;
        load(0, 8'h61, 1'b1);
        drive(); #1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mask_grant[%0d] got=%b want=0000", k, grant); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mask_busy[%0d] got=%b want=0", k, busy); end
        end
        load(1, 8'h81, 1'b0); load(1, 8'h82, 1'b0); load(1, 8'h83, 1'b1);
        drive(); #1;
        for (int k = 0; k < 10; k++) begin
            if (outq.size() >= 2) break;
            step();
        end
        req_mask = 4'b0000;
        repeat (10) step();
        exp_q = '{8'hA1, 8'h81, 8'h82, 8'h83};
        total++; if (outq.size() != exp_q.size()) begin bad++; $display("FAIL mask_len got=%0d want=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= outq.size() || outq[i] !== exp_q[i]) begin bad++; $display("FAIL mask_word[%0d] got=%h want=%h", i, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mask_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_packet();
        test_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) load(0, 8'(8'h91 + i), (i == 4));
        drive(); #1;
        for (int k = 0; k < 10; k++) begin
            if (outq.size() >= 3) break;
            step();
        end
        load(1, 8'hB1, 1'b1);
        drive(); #1;
        aresetn = 1'b0;
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_mid_grant got=%b want=0000", grant); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_tvalid got=%b want=0", m_axis_tvalid); end
        total++; if (trunc_err !== 4'b0000) begin bad++; $display("FAIL rst_mid_trunc got=%b want=0000", trunc_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        outq.delete();
        repeat (12) step();
        exp_q = '{8'hA0, 8'h93, 8'h94, 8'h95, 8'hA1, 8'hB1};
        total++; if (outq.size() != exp_q.size()) begin bad++; $display("FAIL rst_mid_len got=%0d want=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= outq.size() || outq[i] !== exp_q[i]) begin bad++; $display("FAIL rst_mid_word[%0d] got=%h want=%h", i, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        m_axis_tready = 1'b0;
        req_mask      = 4'hF;
        err_clr       = 4'h0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_mask();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
